ballot_controller: RTL and testbench

BALLOT_CONTROLLER -- requirements
Module: ballot_controller

---
 rtl/ballot_controller.sv | 147 ++++++++++++++
 tb/tb_ballot_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ballot_controller.sv
// Ballot controller: arms one ballot per officer request, accepts a single new press,
// keeps saturating per-candidate tallies. Define BALLOT_TIMEOUT_EN to abandon idle armed ballots.

module ballot_tally (
  input  logic       clock,
  input  logic       reset,
  input  logic       inc,
  output logic [7:0] count
);
  always_ff @(posedge clock) begin
    if (reset)                       count <= '0;
    else if (inc && count != 8'hFF)  count <= count + 8'd1;
  end
endmodule

module ballot_controller #(
  parameter int LOCKOUT_CYCLES = 100,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       enable_ballot,
  input  logic [3:0] button_press,
  output logic       valid_vote_casted,
  output logic [7:0] candidate1_vote,
  output logic [7:0] candidate2_vote,
  output logic [7:0] candidate3_vote,
  output logic [7:0] candidate4_vote,
  output logic [1:0] voted_candidate,
  output logic       ballot_armed,
  output logic       busy,
  output logic       rejected,
  output logic       timeout
);
  localparam int NUM_CAND = 4;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAST    = 2'd2;
  localparam logic [1:0] S_LOCKOUT = 2'd3;

  logic [1:0]                     state;
  logic [NUM_CAND-1:0]            btn_q;
  logic [NUM_CAND-1:0]            new_press;
  logic [NUM_CAND-1:0]            inc;
  logic [NUM_CAND-1:0][7:0]       tally;
  logic [31:0]                    lock_cnt;
  logic                           single;
  logic                           multi;
  logic [1:0]                     press_idx;
  logic                           tmo_hit;

  // Only rising edges seen while armed matter; btn_q tracks every cycle so
  // edges from other states are forgotten and held buttons need a re-press.
  always_comb begin
    new_press = button_press & ~btn_q;
    single    = $onehot(new_press);
    multi     = (|new_press) && !single;
    press_idx = '0;
    for (int i = 0; i < NUM_CAND; i++)
      if (new_press[i]) press_idx = 2'(i);
  end

  // Increment lands on the CAST exit edge, together with the valid pulse.
  always_comb begin
    inc = '0;
    if (state == S_CAST && !mode) inc[voted_candidate] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= S_IDLE;
      btn_q             <= '0;
      voted_candidate   <= '0;
      lock_cnt          <= '0;
      valid_vote_casted <= 1'b0;
      rejected          <= 1'b0;
    end else begin
      btn_q             <= button_press;
      valid_vote_casted <= 1'b0;
      rejected          <= 1'b0;
      case (state)
        S_IDLE:
          if (enable_ballot && !mode) state <= S_ARMED;
        S_ARMED:
          if (mode) begin
            state <= S_IDLE;
          end else if (single) begin
            voted_candidate <= press_idx;
            state           <= S_CAST;
          end else begin
            if (multi)   rejected <= 1'b1;
            if (tmo_hit) state    <= S_IDLE;
          end
        S_CAST: begin
          valid_vote_casted <= !mode;
          lock_cnt          <= 32'(LOCKOUT_CYCLES - 1);
          state             <= S_LOCKOUT;
        end
        default:
          if (lock_cnt == '0) state    <= S_IDLE;
          else                lock_cnt <= lock_cnt - 32'd1;
      endcase
    end
  end

`ifdef BALLOT_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        timeout_q;

  assign tmo_hit = (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Counts every armed cycle; a reject does not restart it.
  always_ff @(posedge clock) begin
    if (reset || state != S_ARMED) tmo_cnt <= '0;
    else                           tmo_cnt <= tmo_cnt + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) timeout_q <= 1'b0;
    else       timeout_q <= (state == S_ARMED) && !mode && !single && tmo_hit;
  end

  assign timeout = timeout_q;
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  for (genvar c = 0; c < NUM_CAND; c++) begin : g_tally
    ballot_tally u_tally (
      .clock (clock),
      .reset (reset),
      .inc   (inc[c]),
      .count (tally[c])
    );
  end

  assign candidate1_vote = tally[0];
  assign candidate2_vote = tally[1];
  assign candidate3_vote = tally[2];
  assign candidate4_vote = tally[3];
  assign ballot_armed    = (state == S_ARMED);
  assign busy            = (state == S_CAST) || (state == S_LOCKOUT);

endmodule

// File: tb/tb_ballot_controller.sv
// Self-checking bench for ballot_controller: directed scenarios plus randomized
// ballots checked against a per-candidate saturating tally model.
module tb_ballot_controller;
  localparam int LC = 5;
  localparam int TC = 10;

  logic       clock = 1'b0;
  logic       reset, mode, enable_ballot;
  logic [3:0] button_press;
  logic       valid_vote_casted, ballot_armed, busy, rejected, timeout;
  logic [7:0] candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote;
  logic [1:0] voted_candidate;

  int total = 0;
  int bad   = 0;

  ballot_controller #(.LOCKOUT_CYCLES(LC), .TIMEOUT_CYCLES(TC)) dut (
    .clock             (clock),
    .reset             (reset),
    .mode              (mode),
    .enable_ballot     (enable_ballot),
    .button_press      (button_press),
    .valid_vote_casted (valid_vote_casted),
    .candidate1_vote   (candidate1_vote),
    .candidate2_vote   (candidate2_vote),
    .candidate3_vote   (candidate3_vote),
    .candidate4_vote   (candidate4_vote),
    .voted_candidate   (voted_candidate),
    .ballot_armed      (ballot_armed),
    .busy              (busy),
    .rejected          (rejected),
    .timeout           (timeout)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock); #1;
  endtask

  function automatic logic [31:0] all_tallies;
    return {candidate4_vote, candidate3_vote, candidate2_vote, candidate1_vote};
  endfunction

  task automatic do_reset;
    reset = 1'b1; mode = 1'b0; enable_ballot = 1'b0; button_press = '0;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic arm;
    enable_ballot = 1'b1; tick; enable_ballot = 1'b0;
  endtask

  task automatic wait_lockout(input string tag);
    int g = 0;
    while (busy && g < 100) begin tick; g++; end
    total++;
    if (busy) begin bad++; $display("FAIL %s: still busy after %0d cycles", tag, g); end
  endtask

  task automatic test_reset;
    reset = 1'b1; mode = 1'($urandom); enable_ballot = 1'($urandom); button_press = 4'($urandom);
    tick; tick;
    reset = 1'b0; mode = 1'b0; enable_ballot = 1'b0; button_press = '0;
    total++;
    if ({valid_vote_casted, ballot_armed, busy, rejected, timeout, voted_candidate} !== 7'd0) begin
      bad++; $display("FAIL reset_flags: got %b want 0", {valid_vote_casted, ballot_armed, busy, rejected, timeout, voted_candidate});
    end
    total++;
    if (all_tallies() !== 32'd0) begin bad++; $display("FAIL reset_tallies: got %h want 0", all_tallies()); end
    // reset arriving while the vote is in CAST must drop the increment
    arm; button_press = 4'b1000; tick;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL reset_cast_busy: got %b want 1", busy); end
    reset = 1'b1; button_press = '0; tick; reset = 1'b0;
    total++;
    if ({valid_vote_casted, candidate4_vote} !== 9'd0) begin
      bad++; $display("FAIL reset_in_cast: got valid=%b c4=%0d want 0/0", valid_vote_casted, candidate4_vote);
    end
    tick;
    total++;
    if ({valid_vote_casted, candidate4_vote, busy} !== 10'd0) begin
      bad++; $display("FAIL reset_in_cast_after: got valid=%b c4=%0d busy=%b want 0", valid_vote_casted, candidate4_vote, busy);
    end
  endtask

  task automatic test_single_vote;
    int n;
    do_reset; arm;
    total++;
    if (ballot_armed !== 1'b1) begin bad++; $display("FAIL arm: got %b want 1", ballot_armed); end
    button_press = 4'b0010; tick;
    total++;
    if ({busy, valid_vote_casted} !== 2'b10) begin bad++; $display("FAIL cast_state: got busy/valid=%b want 10", {busy, valid_vote_casted}); end
    button_press = '0; tick;
    total++;
    if (valid_vote_casted !== 1'b1) begin bad++; $display("FAIL vote_valid: got %b want 1", valid_vote_casted); end
    total++;
    if (all_tallies() !== 32'h0000_0100) begin bad++; $display("FAIL vote_tally: got %h want 00000100", all_tallies()); end
    total++;
    if (voted_candidate !== 2'd1) begin bad++; $display("FAIL vote_idx: got %0d want 1", voted_candidate); end
    n = 2;
    tick;
    total++;
    if (valid_vote_casted !== 1'b0) begin bad++; $display("FAIL valid_width: got %b want 0", valid_vote_casted); end
    if (busy) n++;
    for (int g = 0; g < 200 && busy; g++) begin tick; if (busy) n++; end
    total++;
    if (n !== LC + 1) begin bad++; $display("FAIL busy_len: got %0d want %0d", n, LC + 1); end
  endtask

  task automatic test_multi_press;
    do_reset; arm;
    button_press = 4'b0101; tick;
    total++;
    if ({rejected, ballot_armed} !== 2'b11) begin bad++; $display("FAIL reject: got rej/armed=%b want 11", {rejected, ballot_armed}); end
    total++;
    if (all_tallies() !== 32'd0) begin bad++; $display("FAIL reject_tally: got %h want 0", all_tallies()); end
    button_press = '0; tick;
    total++;
    if ({rejected, ballot_armed, valid_vote_casted} !== 3'b010) begin
      bad++; $display("FAIL reject_after: got rej/armed/valid=%b want 010", {rejected, ballot_armed, valid_vote_casted});
    end
    mode = 1'b1; tick; mode = 1'b0;
  endtask

  task automatic test_saturation;
    int pulses = 0;
    do_reset;
    for (int v = 0; v < 256; v++) begin
      arm; button_press = 4'b0100; tick;
      button_press = '0; tick;
      if (valid_vote_casted) pulses++;
      for (int g = 0; g < 50 && busy; g++) begin tick; if (valid_vote_casted) pulses++; end
    end
    total++;
    if (candidate3_vote !== 8'd255) begin bad++; $display("FAIL sat_tally: got %0d want 255", candidate3_vote); end
    total++;
    if (pulses !== 256) begin bad++; $display("FAIL sat_pulses: got %0d want 256", pulses); end
    total++;
    if ({candidate1_vote, candidate2_vote, candidate4_vote} !== 24'd0) begin
      bad++; $display("FAIL sat_others: got %h want 0", {candidate1_vote, candidate2_vote, candidate4_vote});
    end
  endtask

  task automatic test_lockout_press;
    int seen = 0;
    do_reset; arm;
    button_press = 4'b0001; tick;
    button_press = '0; tick;
    total++;
    if (candidate1_vote !== 8'd1) begin bad++; $display("FAIL lock_first: got %0d want 1", candidate1_vote); end
    button_press = 4'b0001; enable_ballot = 1'b1; tick;
    enable_ballot = 1'b0;
    wait_lockout("lock_wait");
    total++;
    if (ballot_armed !== 1'b0) begin bad++; $display("FAIL lock_enable_ignored: got armed=%b want 0", ballot_armed); end
    arm;
    for (int j = 0; j < 3; j++) begin tick; if (valid_vote_casted || busy) seen++; end
    total++;
    if (seen !== 0 || candidate1_vote !== 8'd1 || ballot_armed !== 1'b1) begin
      bad++; $display("FAIL held_button: got seen=%0d c1=%0d armed=%b want 0/1/1", seen, candidate1_vote, ballot_armed);
    end
    button_press = '0; tick;
    button_press = 4'b0001; tick;
    button_press = '0; tick;
    total++;
    if ({valid_vote_casted, candidate1_vote} !== {1'b1, 8'd2}) begin
      bad++; $display("FAIL repress: got valid=%b c1=%0d want 1/2", valid_vote_casted, candidate1_vote);
    end
    wait_lockout("repress_wait");
  endtask

  task automatic test_mode_priority;
    do_reset; arm;
    mode = 1'b1; button_press = 4'b0010; tick;
    total++;
    if ({ballot_armed, busy} !== 2'b00) begin bad++; $display("FAIL mode_exit: got armed/busy=%b want 00", {ballot_armed, busy}); end
    tick;
    total++;
    if (valid_vote_casted !== 1'b0 || all_tallies() !== 32'd0) begin
      bad++; $display("FAIL mode_no_vote: got valid=%b tallies=%h want 0/0", valid_vote_casted, all_tallies());
    end
    enable_ballot = 1'b1; tick;
    total++;
    if (ballot_armed !== 1'b0) begin bad++; $display("FAIL mode_no_arm: got %b want 0", ballot_armed); end
    mode = 1'b0; enable_ballot = 1'b0; button_press = '0; tick;
  endtask

`ifdef BALLOT_TIMEOUT_EN
  task automatic test_timeout;
    do_reset; arm;
    for (int j = 1; j < TC; j++) begin
      button_press = (j == 4) ? 4'b0011 : 4'b0000;
      tick;
      total++;
      if ({ballot_armed, timeout} !== 2'b10) begin bad++; $display("FAIL tmo_early[%0d]: got armed/tmo=%b want 10", j, {ballot_armed, timeout}); end
    end
    button_press = '0; tick;
    total++;
    if ({ballot_armed, timeout} !== 2'b01) begin bad++; $display("FAIL tmo_fire: got armed/tmo=%b want 01", {ballot_armed, timeout}); end
    tick;
    total++;
    if ({ballot_armed, timeout} !== 2'b00) begin bad++; $display("FAIL tmo_pulse: got armed/tmo=%b want 00", {ballot_armed, timeout}); end
  endtask
`endif

  task automatic test_random;
    int exp_t[4];
    int c;
    logic [3:0] pat;
    do_reset;
    for (int i = 0; i < 4; i++) exp_t[i] = 0;
    for (int b = 0; b < 40; b++) begin
      arm;
      for (int k = $urandom_range(0, 2); k > 0; k--) tick;
      if ($urandom_range(0, 1) == 1) begin
        do pat = 4'($urandom_range(0, 15)); while ($countones(pat) < 2);
        button_press = pat; tick;
        total++;
        if ({rejected, ballot_armed} !== 2'b11) begin bad++; $display("FAIL rnd_reject[%0d]: pat=%b got %b want 11", b, pat, {rejected, ballot_armed}); end
        button_press = '0; tick;
      end
      c = $urandom_range(0, 3);
      button_press = 4'(1 << c); tick;
      button_press = '0; enable_ballot = 1'($urandom); tick;
      enable_ballot = 1'b0;
      exp_t[c] = (exp_t[c] == 255) ? 255 : exp_t[c] + 1;
      total++;
      if (valid_vote_casted !== 1'b1 || voted_candidate !== 2'(c)) begin
        bad++; $display("FAIL rnd_vote[%0d]: got valid=%b idx=%0d want 1/%0d", b, valid_vote_casted, voted_candidate, c);
      end
      total++;
      if (all_tallies() !== {8'(exp_t[3]), 8'(exp_t[2]), 8'(exp_t[1]), 8'(exp_t[0])}) begin
        bad++; $display("FAIL rnd_tally[%0d]: got %h want %h", b, all_tallies(), {8'(exp_t[3]), 8'(exp_t[2]), 8'(exp_t[1]), 8'(exp_t[0])});
      end
      button_press = 4'($urandom); tick;
      button_press = '0;
      wait_lockout("rnd_wait");
      tick;
    end
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; enable_ballot = 1'b0; button_press = '0;
    test_reset;
    test_single_vote;
    test_multi_press;
    test_saturation;
    test_lockout_press;
    test_mode_priority;
`ifdef BALLOT_TIMEOUT_EN
    test_timeout;
`endif
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
